// File: rtl/rgb_clip_write_scheduler.sv
// Shared-clipper sequencer for an even/odd RGB pixel pair.
// Clips six CSC results, packs them into three words, writes them to SRAM.
module rgb_clip_write_scheduler #(
    parameter int ADDR_W = 18,
    parameter int CNT_W  = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  pair_count,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_r0,
    input  logic [15:0]       in_g0,
    input  logic [15:0]       in_b0,
    input  logic [15:0]       in_r1,
    input  logic [15:0]       in_g1,
    input  logic [15:0]       in_b1,
    output logic [15:0]       clip_value,
    input  logic [7:0]        clip_result,
    output logic              sram_req,
    input  logic              sram_gnt,
    output logic [ADDR_W-1:0] SRAM_address,
    output logic [15:0]       SRAM_write_data,
    output logic              SRAM_we_n
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD,
        S_C0, S_C1, S_C2, S_C3, S_C4, S_C5,
        S_W0, S_W1, S_W2, S_DONE
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_in_ready;
    logic               r_req;
    logic [ADDR_W-1:0]  r_addr;
    logic [CNT_W-1:0]   r_pairs;
    logic [5:0][15:0]   r_op;
    logic [5:0][7:0]    r_byte;
    logic [15:0]        w_clip_value;
    logic [15:0]        w_wdata;

    // Sequencer: handshake, six clips, three granted writes per pair.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_in_ready <= 1'b0;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_pairs    <= '0;
            r_op       <= '0;
            r_byte     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr  <= base_addr;
                        r_pairs <= pair_count;
                        if (pair_count == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_LOAD;
                            r_busy     <= 1'b1;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_op       <= {in_b1, in_g1, in_r1,
                                       in_b0, in_g0, in_r0};
                        r_in_ready <= 1'b0;
                        r_state    <= S_C0;
                    end
                end
                S_C0: begin
                    r_byte[0] <= clip_result;
                    r_state   <= S_C1;
                end
                S_C1: begin
                    r_byte[1] <= clip_result;
                    r_state   <= S_C2;
                end
                S_C2: begin
                    r_byte[2] <= clip_result;
                    r_state   <= S_C3;
                end
                S_C3: begin
                    r_byte[3] <= clip_result;
                    r_state   <= S_C4;
                end
                S_C4: begin
                    r_byte[4] <= clip_result;
                    r_state   <= S_C5;
                end
                S_C5: begin
                    r_byte[5] <= clip_result;
                    r_req     <= 1'b1;
                    r_state   <= S_W0;
                end
                S_W0: begin
                    if (sram_gnt) begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_state <= S_W1;
                    end
                end
                S_W1: begin
                    if (sram_gnt) begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_state <= S_W2;
                    end
                end
                S_W2: begin
                    if (sram_gnt) begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_req   <= 1'b0;
                        r_pairs <= r_pairs - CNT_W'(1);
                        if (r_pairs == CNT_W'(1)) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= S_LOAD;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Operand steering to the shared clipper and packed word selection.
    always_comb begin
        w_clip_value = '0;
        w_wdata      = '0;
        case (r_state)
            S_C0:    w_clip_value = r_op[0];
            S_C1:    w_clip_value = r_op[1];
            S_C2:    w_clip_value = r_op[2];
            S_C3:    w_clip_value = r_op[3];
            S_C4:    w_clip_value = r_op[4];
            S_C5:    w_clip_value = r_op[5];
            S_W0:    w_wdata = {r_byte[0], r_byte[1]};
            S_W1:    w_wdata = {r_byte[2], r_byte[3]};
            S_W2:    w_wdata = {r_byte[4], r_byte[5]};
            default: w_wdata = '0;
        endcase
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign in_ready        = r_in_ready;
    assign sram_req        = r_req;
    assign SRAM_address    = r_addr;
    assign clip_value      = w_clip_value;
    assign SRAM_write_data = w_wdata;
    assign SRAM_we_n       = ~(r_req & sram_gnt);

endmodule

// File: tb/tb_rgb_clip_write_scheduler.sv
// Bench for rgb_clip_write_scheduler: queue model of expected SRAM writes,
// per-cycle compare process and directed timing/boundary checks.
module tb_rgb_clip_write_scheduler;

    localparam int AW = 18;
    localparam int CW = 16;

    logic          Clock = 1'b0;
    logic          Resetn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] pair_count = '0;
    logic          busy;
    logic          done;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_r0 = '0;
    logic [15:0]   in_g0 = '0;
    logic [15:0]   in_b0 = '0;
    logic [15:0]   in_r1 = '0;
    logic [15:0]   in_g1 = '0;
    logic [15:0]   in_b1 = '0;
    logic [15:0]   clip_value;
    logic [7:0]    clip_result;
    logic          sram_req;
    logic          sram_gnt = 1'b1;
    logic [AW-1:0] SRAM_address;
    logic [15:0]   SRAM_write_data;
    logic          SRAM_we_n;

    rgb_clip_write_scheduler #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .Clock(Clock), .Resetn(Resetn), .start(start),
        .base_addr(base_addr), .pair_count(pair_count),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r0(in_r0), .in_g0(in_g0), .in_b0(in_b0),
        .in_r1(in_r1), .in_g1(in_g1), .in_b1(in_b1),
        .clip_value(clip_value), .clip_result(clip_result),
        .sram_req(sram_req), .sram_gnt(sram_gnt),
        .SRAM_address(SRAM_address),
        .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n(SRAM_we_n)
    );

    always #5 Clock = ~Clock;

    // Saturating clip of a signed value into 0..255.
    function automatic logic [7:0] clipf(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        if (s < 0) return 8'h00;
        if (s > 255) return 8'hFF;
        return 8'(s);
    endfunction

    assign clip_result = clipf(clip_value);

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_wr = 0;
    int n_done = 0;
    int first_wr = -1;
    bit ir_seen = 1'b0;

    logic [AW-1:0] q_addr[$];
    logic [15:0]   q_data[$];
    logic [AW-1:0] m_addr = '0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model_pair(input logic [5:0][15:0] v);
        for (int k = 0; k < 3; k++) begin
            q_addr.push_back(m_addr);
            q_data.push_back({clipf(v[2*k]), clipf(v[2*k+1])});
            m_addr = m_addr + 1'b1;
        end
    endtask

    // Compare process: every cycle a request is up, address/data must match
    // the head of the expected-write queue; a write pops it.
    always @(negedge Clock) begin
        if (Resetn) begin
            if (in_ready) ir_seen = 1'b1;
            if (done) n_done++;
            if (sram_req) begin
                chk("req_expected", 32'(q_addr.size() > 0), 32'd1);
                if (q_addr.size() > 0) begin
                    chk("wr_addr", 32'(SRAM_address), 32'(q_addr[0]));
                    chk("wr_data", 32'(SRAM_write_data), 32'(q_data[0]));
                end
                chk("we_n_req", 32'(SRAM_we_n), 32'(!sram_gnt));
                if (!SRAM_we_n) begin
                    if (first_wr < 0) first_wr = cyc;
                    n_wr++;
                    if (q_addr.size() > 0) begin
                        void'(q_addr.pop_front());
                        void'(q_data.pop_front());
                    end
                end
            end else begin
                chk("we_n_idle", 32'(SRAM_we_n), 32'd1);
                if (!SRAM_we_n) n_wr++;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_sram_req"}, 32'(sram_req), 32'd0);
        chk({tag, "_we_n"}, 32'(SRAM_we_n), 32'd1);
        chk({tag, "_clip_value"}, 32'(clip_value), 32'd0);
        chk({tag, "_addr"}, 32'(SRAM_address), 32'd0);
        chk({tag, "_wdata"}, 32'(SRAM_write_data), 32'd0);
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [CW-1:0] n,
                            output int s_cyc);
        @(posedge Clock);
        #1;
        start = 1'b1;
        base_addr = b;
        pair_count = n;
        m_addr = b;
        @(posedge Clock);
        #1;
        s_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic send_pair(input logic [5:0][15:0] v, input int dly,
                             input bit use_model, output int hs);
        bit found;
        found = 1'b0;
        hs = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock);
            if (in_ready) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            chk("in_ready_timeout", 32'd0, 32'd1);
            return;
        end
        repeat (dly) @(negedge Clock);
        in_r0 = v[0]; in_g0 = v[1]; in_b0 = v[2];
        in_r1 = v[3]; in_g1 = v[4]; in_b1 = v[5];
        in_valid = 1'b1;
        if (use_model) model_pair(v);
        @(posedge Clock);
        #1;
        hs = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clock);
            if (done) begin
                dc = cyc;
                return;
            end
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    logic [5:0][15:0] v_nom = {16'h00BC, 16'h009A, 16'h0078,
                               16'h0056, 16'h0034, 16'h0012};
    logic [5:0][15:0] v_sat = {16'h7FFF, 16'h00FF, 16'h0100,
                               16'h8000, 16'h0123, 16'hFF80};
    logic [5:0][15:0] v_mix = {16'h0001, 16'hFFFF, 16'h0080,
                               16'h0200, 16'h00AA, 16'h0055};

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int s, hs, hs2, dc, w0, d0;

        // Reset state
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check_reset_outputs("reset");
        @(posedge Clock);
        #1;
        Resetn = 1'b1;

        // Nominal pair
        w0 = n_wr; d0 = n_done; first_wr = -1;
        do_start(18'h01000, 16'd1, s);
        @(negedge Clock);
        chk("nom_busy", 32'(busy), 32'd1);
        chk("nom_in_ready", 32'(in_ready), 32'd1);
        send_pair(v_nom, 0, 1'b1, hs);
        chk("nom_model_w0", 32'(q_data[0]), 32'h1234);
        chk("nom_model_w1", 32'(q_data[1]), 32'h5678);
        chk("nom_model_w2", 32'(q_data[2]), 32'h9ABC);
        chk("nom_model_a2", 32'(q_addr[2]), 32'h01002);
        wait_done(dc);
        chk("nom_pair_cycles", 32'(dc - hs), 32'd9);
        chk("nom_first_write", 32'(first_wr - hs), 32'd6);
        chk("nom_busy_at_done", 32'(busy), 32'd0);
        repeat (6) @(negedge Clock);
        chk("nom_writes", 32'(n_wr - w0), 32'd3);
        chk("nom_done_pulses", 32'(n_done - d0), 32'd1);
        chk("nom_queue_empty", 32'(q_addr.size()), 32'd0);

        // Saturation
        w0 = n_wr;
        do_start(18'h00200, 16'd1, s);
        send_pair(v_sat, 0, 1'b1, hs);
        chk("sat_model_w0", 32'(q_data[0]), 32'h00FF);
        chk("sat_model_w1", 32'(q_data[1]), 32'h00FF);
        chk("sat_model_w2", 32'(q_data[2]), 32'hFFFF);
        wait_done(dc);
        repeat (4) @(negedge Clock);
        chk("sat_writes", 32'(n_wr - w0), 32'd3);
        chk("sat_queue_empty", 32'(q_addr.size()), 32'd0);

        // Grant stall of four cycles in W1
        w0 = n_wr; d0 = n_done;
        do_start(18'h02000, 16'd1, s);
        send_pair(v_mix, 0, 1'b1, hs);
        repeat (7) @(posedge Clock);
        #1;
        sram_gnt = 1'b0;
        repeat (4) @(posedge Clock);
        #1;
        sram_gnt = 1'b1;
        wait_done(dc);
        chk("stall_pair_cycles", 32'(dc - hs), 32'd13);
        repeat (4) @(negedge Clock);
        chk("stall_writes", 32'(n_wr - w0), 32'd3);
        chk("stall_done_pulses", 32'(n_done - d0), 32'd1);
        chk("stall_queue_empty", 32'(q_addr.size()), 32'd0);

        // Zero count
        w0 = n_wr; d0 = n_done; ir_seen = 1'b0;
        do_start(18'h03000, 16'd0, s);
        wait_done(dc);
        chk("zero_done_latency", 32'(dc - s), 32'd0);
        repeat (6) @(negedge Clock);
        chk("zero_in_ready", 32'(ir_seen), 32'd0);
        chk("zero_writes", 32'(n_wr - w0), 32'd0);
        chk("zero_done_pulses", 32'(n_done - d0), 32'd1);

        // Start while busy is ignored
        w0 = n_wr; d0 = n_done;
        do_start(18'h00500, 16'd1, s);
        send_pair(v_nom, 0, 1'b1, hs);
        start = 1'b1;
        base_addr = 18'h00700;
        pair_count = 16'd5;
        @(posedge Clock);
        #1;
        start = 1'b0;
        wait_done(dc);
        chk("ign_pair_cycles", 32'(dc - hs), 32'd9);
        repeat (12) @(negedge Clock);
        chk("ign_writes", 32'(n_wr - w0), 32'd3);
        chk("ign_done_pulses", 32'(n_done - d0), 32'd1);
        chk("ign_busy", 32'(busy), 32'd0);
        chk("ign_in_ready", 32'(in_ready), 32'd0);

        // Address wrap over two pairs, second input delayed
        w0 = n_wr; d0 = n_done;
        do_start(18'h3FFFE, 16'd2, s);
        send_pair(v_nom, 0, 1'b1, hs);
        send_pair(v_sat, 3, 1'b1, hs2);
        chk("wrap_model_a3", 32'(q_addr[0]), 32'h00001);
        chk("wrap_pair2_gap", 32'(hs2 - hs), 32'd13);
        wait_done(dc);
        chk("wrap_pair2_cycles", 32'(dc - hs2), 32'd9);
        repeat (4) @(negedge Clock);
        chk("wrap_writes", 32'(n_wr - w0), 32'd6);
        chk("wrap_done_pulses", 32'(n_done - d0), 32'd1);
        chk("wrap_queue_empty", 32'(q_addr.size()), 32'd0);

        // Reset during C3 discards the pair
        w0 = n_wr; d0 = n_done;
        do_start(18'h04000, 16'd1, s);
        send_pair(v_mix, 0, 1'b0, hs);
        repeat (3) @(posedge Clock);
        #1;
        Resetn = 1'b0;
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        @(negedge Clock);
        check_reset_outputs("midrst");
        repeat (15) @(negedge Clock);
        chk("midrst_writes", 32'(n_wr - w0), 32'd0);
        chk("midrst_done", 32'(n_done - d0), 32'd0);

        // Fresh start after reset
        w0 = n_wr; d0 = n_done;
        do_start(18'h05000, 16'd1, s);
        send_pair(v_nom, 0, 1'b1, hs);
        wait_done(dc);
        chk("post_pair_cycles", 32'(dc - hs), 32'd9);
        repeat (4) @(negedge Clock);
        chk("post_writes", 32'(n_wr - w0), 32'd3);
        chk("post_done_pulses", 32'(n_done - d0), 32'd1);
        chk("post_queue_empty", 32'(q_addr.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_clip_write_scheduler.md
Name: rgb_clip_write_scheduler

Overview:
Sequences one shared 16-bit-to-8-bit saturating clipper across the six colour-space-conversion results of an even/odd pixel pair (R0,G0,B0,R1,G1,B1). Packs the six clipped bytes into three 16-bit RGB words and writes them to consecutive SRAM addresses. Sits between the CSC MAC datapath (upstream, valid/ready) and the top-level SRAM arbiter (downstream, req/gnt). Runs for a programmed number of pixel pairs per start.

Parameters:
ADDR_W, 18, SRAM word-address width; address arithmetic wraps modulo 2^ADDR_W
CNT_W, 16, width of the pixel-pair count

Ports:
Clock  input  1  system clock, all state updates on rising edge
Resetn  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; sampled only in IDLE
base_addr  input  ADDR_W  first SRAM write address, latched on accepted start
pair_count  input  CNT_W  number of pixel pairs, latched on accepted start
busy  output  1  high from the cycle after start acceptance until done
done  output  1  one-cycle pulse at the end of a run
in_valid  input  1  upstream has a pair on in_r0..in_b1
in_ready  output  1  high only in LOAD
in_r0, in_g0, in_b0, in_r1, in_g1, in_b1  input  16 each  signed CSC results
clip_value  output  16  operand driven to the shared clipper
clip_result  input  8  clipper output, combinational from clip_value
sram_req  output  1  write request to the arbiter
sram_gnt  input  1  arbiter grant
SRAM_address  output  ADDR_W  write address
SRAM_write_data  output  16  packed write data
SRAM_we_n  output  1  active-low write enable = ~(sram_req & sram_gnt)

Behaviour:
- Reset, and every cycle Resetn=0: state IDLE; busy, done, in_ready, sram_req = 0; SRAM_we_n = 1; clip_value, SRAM_address, SRAM_write_data, and all internal counters and byte registers = 0. A reset mid-run discards the in-flight pair. No further writes occur.
- States: IDLE, LOAD, C0..C5, W0..W2, DONE.
- IDLE:
  - start=1 latches base_addr into the address counter and pair_count into pairs_left.
  - If pair_count = 0, go to DONE. Otherwise go to LOAD.
  - start is ignored in every state other than IDLE.
- LOAD:
  - in_ready = 1.
  - On in_valid & in_ready, register all six inputs and go to C0. in_ready is 0 in the next cycle.
- C0..C5: one clip per cycle, in the order R0,G0,B0,R1,G1,B1.
  - clip_value is the selected operand register.
  - clip_result is captured into byte k at the end of state Ck.
  - Clip function: upper byte 0 passes the low byte; otherwise a negative value gives 0x00 and a positive value gives 0xFF.
- W0..W2:
  - sram_req = 1.
  - SRAM_write_data: W0 = {R0,G0}, W1 = {B0,R1}, W2 = {G1,B1}.
  - SRAM_address = address counter.
  - While sram_gnt = 0, stay in the current W state with address and data held stable. SRAM_we_n stays 1.
  - A write completes in a cycle where sram_gnt = 1. The address then increments (wrapping) and the state advances.
- After the W2 write: pairs_left decrements. Go to DONE if it reaches 0, else go to LOAD.
- DONE: done = 1 for one cycle, busy drops, return to IDLE.
- Latency with in_valid and sram_gnt held high: the first write cycle is 7 cycles after the input handshake edge. A pair takes 10 cycles (LOAD, 6 clip, 3 write). N pairs produce exactly 3N writes at addresses base .. base+3N-1 (mod 2^ADDR_W).
- Simultaneous events:
  - in_valid asserted outside LOAD: no transfer.
  - sram_gnt outside W states: ignored, and SRAM_we_n stays 1.

Test Plan:
- Nominal pair: base 0x01000, count 1, inputs 0x0012, 0x0034, 0x0056, 0x0078, 0x009A, 0x00BC, gnt = 1 -> writes 0x01000:0x1234, 0x01001:0x5678, 0x01002:0x9ABC; one done pulse; no fourth write.
- Saturation: inputs 0xFF80, 0x0123, 0x8000, 0x0100, 0x00FF, 0x7FFF -> words 0x00FF, 0x00FF, 0xFFFF.
- Grant stall: hold gnt = 0 for 4 cycles during W1 -> SRAM_we_n = 1 and address/data unchanged throughout the stall; a single write is issued once gnt returns; the full pair then takes 14 cycles.
- Zero count and ignored start: pair_count = 0 -> done one cycle after start, in_ready never high, no writes. A start pulse during busy has no effect on the count or address.
- Wrap and multi-pair: base 0x3FFFE, count 2, upstream in_valid delayed 3 cycles for the second pair -> six writes at 0x3FFFE, 0x3FFFF, 0x00000, 0x00001, 0x00002, 0x00003.
- Reset mid-run: Resetn = 0 for one cycle during C3 -> next cycle all outputs are at reset values, state is IDLE, no SRAM write is issued, and a fresh start behaves nominally.
